// File: rtl/remote_pkt_arbiter.sv
// Round-robin, packet-locked arbiter that merges NUM_SRC non-backpressured AXIS sources onto one TX port.
// Optional REMOTE_ARB_STRICT_PRIO_EN: fixed priority (source 0 highest) instead of round-robin.
module remote_pkt_arbiter #(
  parameter int NUM_SRC               = 2,
  parameter int FIFO_DEPTH            = 16,
  parameter int AXIS_TDATA_WIDTH      = 64,
  parameter int STREAMING_TDEST_WIDTH = 8,
  localparam int KEEP_W                = AXIS_TDATA_WIDTH / 8,
  localparam int AXIS_PKT_STRUCT_WIDTH = AXIS_TDATA_WIDTH + KEEP_W + STREAMING_TDEST_WIDTH + 2,
  localparam int SW                    = $clog2(NUM_SRC)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NUM_SRC-1:0][AXIS_PKT_STRUCT_WIDTH-1:0]     i_axis_pkt,
  output logic                                              o_axis_tvalid,
  input  logic                                              i_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]                       o_axis_tdata,
  output logic [KEEP_W-1:0]                                 o_axis_tkeep,
  output logic [STREAMING_TDEST_WIDTH-1:0]                  o_axis_tdest,
  output logic                                              o_axis_tlast,
  output logic [SW-1:0]                                     o_grant_id,
  output logic [NUM_SRC-1:0]                                o_fifo_full,
  output logic [NUM_SRC-1:0]                                o_overflow
);

  // state  | meaning
  // IDLE   | no packet locked; pick next non-empty FIFO
  // LOCKED | only locked_src is drained until its tlast beat is accepted

  localparam int ENT_W = AXIS_PKT_STRUCT_WIDTH - 1;  // {tlast, tdest, tkeep, tdata}
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t             state;
  logic [SW-1:0]      locked_src, rr_ptr, next_src, arb_base, cand, pop_src;
  logic               cand_found, load, last_accept, arb_en, grant, pop_any;
  logic [NUM_SRC-1:0] push, wr_en, pop, drop, empty;
  logic [AW:0]        wr_ptr [NUM_SRC];
  logic [AW:0]        rd_ptr [NUM_SRC];
  logic [AW:0]        cnt_nxt [NUM_SRC];
  logic [ENT_W-1:0]   mem [NUM_SRC][FIFO_DEPTH];
  logic [ENT_W-1:0]   head [NUM_SRC];

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      push[s]  = i_axis_pkt[s][AXIS_PKT_STRUCT_WIDTH-1];
      empty[s] = (wr_ptr[s] == rd_ptr[s]);
      head[s]  = mem[s][rd_ptr[s][AW-1:0]];
    end
  end

  assign next_src    = (locked_src == SW'(NUM_SRC - 1)) ? '0 : locked_src + 1'b1;
  assign load        = !o_axis_tvalid || i_axis_tready;
  assign last_accept = o_axis_tvalid && o_axis_tlast && i_axis_tready;
  // Re-arbitrate on the edge the tlast beat leaves, so packets switch without a bubble.
  assign arb_en      = (state == ST_IDLE) || last_accept;

`ifdef REMOTE_ARB_STRICT_PRIO_EN
  assign arb_base = '0;
`else
  assign arb_base = (state == ST_IDLE) ? rr_ptr : next_src;
`endif

  always_comb begin
    int j;
    j          = 0;
    cand       = '0;
    cand_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(arb_base) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!cand_found && !empty[SW'(j)]) begin
        cand       = SW'(j);
        cand_found = 1'b1;
      end
    end
  end

  assign grant = arb_en && cand_found && load;

  // Once the locked packet's tlast sits in the output register, stop draining that source.
  always_comb begin
    pop     = '0;
    pop_src = locked_src;
    pop_any = 1'b0;
    if (grant) begin
      pop_src = cand;
      pop_any = 1'b1;
    end else if (state == ST_LOCKED && load && !empty[locked_src] &&
                 !(o_axis_tvalid && o_axis_tlast)) begin
      pop_any = 1'b1;
    end
    pop[pop_src] = pop_any;
  end

  assign wr_en = push & (~o_fifo_full | pop);
  assign drop  = push & o_fifo_full & ~pop;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++)
      cnt_nxt[s] = wr_ptr[s] - rd_ptr[s] + {{AW{1'b0}}, wr_en[s]} - {{AW{1'b0}}, pop[s]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
      end
      o_fifo_full <= '0;
      o_overflow  <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (wr_en[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s])   rd_ptr[s] <= rd_ptr[s] + 1'b1;
        o_fifo_full[s] <= (cnt_nxt[s] == (AW+1)'(FIFO_DEPTH));
      end
      o_overflow <= o_overflow | drop;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++)
      if (wr_en[s]) mem[s][wr_ptr[s][AW-1:0]] <= i_axis_pkt[s][ENT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      locked_src    <= '0;
      rr_ptr        <= '0;
      o_axis_tvalid <= 1'b0;
      o_axis_tdata  <= '0;
      o_axis_tkeep  <= '0;
      o_axis_tdest  <= '0;
      o_axis_tlast  <= 1'b0;
      o_grant_id    <= '0;
    end else begin
      if (pop_any) begin
        o_axis_tvalid <= 1'b1;
        {o_axis_tlast, o_axis_tdest, o_axis_tkeep, o_axis_tdata} <= head[pop_src];
        o_grant_id    <= pop_src;
      end else if (i_axis_tready) begin
        o_axis_tvalid <= 1'b0;
      end

      if (grant) begin
        state      <= ST_LOCKED;
        locked_src <= cand;
      end else if (last_accept) begin
        state <= ST_IDLE;
      end

`ifdef REMOTE_ARB_STRICT_PRIO_EN
      rr_ptr <= '0;
`else
      if (last_accept) rr_ptr <= next_src;
`endif
    end
  end

endmodule

// File: tb/tb_remote_pkt_arbiter.sv
// Directed self-checking bench for remote_pkt_arbiter (NUM_SRC=2, FIFO_DEPTH=16).
// Expectations switch with REMOTE_ARB_STRICT_PRIO_EN where arbitration order differs.
module tb_remote_pkt_arbiter;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 16;
  localparam int PW      = 64 + 8 + 8 + 2;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_SRC-1:0][PW-1:0]   pkt;
  logic                         tvalid, tready, tlast;
  logic [63:0]                  tdata;
  logic [7:0]                   tkeep, tdest;
  logic [0:0]                   gid;
  logic [NUM_SRC-1:0]           full, ovf;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] mon_data [$];
  int          mon_gid  [$];
  logic        mon_last [$];
  int          mon_cyc  [$];

  remote_pkt_arbiter #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(DEPTH),
                       .AXIS_TDATA_WIDTH(64), .STREAMING_TDEST_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_axis_pkt(pkt),
    .o_axis_tvalid(tvalid), .i_axis_tready(tready), .o_axis_tdata(tdata),
    .o_axis_tkeep(tkeep), .o_axis_tdest(tdest), .o_axis_tlast(tlast),
    .o_grant_id(gid), .o_fifo_full(full), .o_overflow(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      mon_data.push_back(tdata);
      mon_gid.push_back(int'(gid));
      mon_last.push_back(tlast);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [63:0] d, input logic last);
    return {1'b1, last, d[7:0], 8'hFF, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_data.delete(); mon_gid.delete(); mon_last.delete(); mon_cyc.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && mon_data.size() < n; c++) step();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pkt    = '0;
    tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  int          t3_g [9];
  logic [63:0] t3_d [9];
  int          eg;
  logic [63:0] ed;

  initial begin
`ifdef REMOTE_ARB_STRICT_PRIO_EN
    t3_g = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    t3_d = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'hA0, 64'hA1, 64'hA2};
`else
    t3_g = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    t3_d = '{64'h10, 64'hA0, 64'hA1, 64'hA2, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15};
`endif

    // reset state and single-beat latency
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_grant", gid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    step();
    tready = 1'b1;
    pkt[0] = mk(64'hA5, 1'b1);
    step();
    pkt = '0;
    @(negedge clk);
    chk("t1_tvalid_n1", tvalid, 0);
    step();
    @(negedge clk);
    chk("t1_tvalid_n2", tvalid, 1);
    chk("t1_tdata", tdata, 64'hA5);
    chk("t1_tkeep", tkeep, 8'hFF);
    chk("t1_tdest", tdest, 8'hA5);
    chk("t1_tlast", tlast, 1);
    chk("t1_grant", gid, 0);
    step();
    @(negedge clk);
    chk("t1_tvalid_n3", tvalid, 0);

    // both sources, single-beat packets every cycle
    do_reset();
    tready = 1'b1;
    mon_clear();
    for (int i = 0; i < 8; i++) begin
      pkt[0] = mk(64'(i), 1'b1);
      pkt[1] = mk(64'h80 + 64'(i), 1'b1);
      step();
    end
    pkt = '0;
    wait_beats(16, 60);
    chk("t2_count", mon_data.size(), 16);
    for (int k = 0; k < 16; k++) begin
`ifdef REMOTE_ARB_STRICT_PRIO_EN
      eg = (k < 8) ? 0 : 1;
      ed = (k < 8) ? 64'(k) : 64'h80 + 64'(k - 8);
`else
      eg = k % 2;
      ed = (k % 2 == 0) ? 64'(k / 2) : 64'h80 + 64'(k / 2);
`endif
      if (k < mon_data.size()) begin
        chk($sformatf("t2_grant%0d", k), mon_gid[k], eg);
        chk($sformatf("t2_data%0d", k), mon_data[k], ed);
      end
    end
    if (mon_data.size() >= 16) chk("t2_span", mon_cyc[15] - mon_cyc[0], 15);

    // 3-beat packet on source 1 against continuous source 0
    do_reset();
    tready = 1'b1;
    mon_clear();
    for (int i = 0; i < 6; i++) begin
      pkt[0] = mk(64'h10 + 64'(i), 1'b1);
      pkt[1] = (i < 3) ? mk(64'hA0 + 64'(i), i == 2) : '0;
      step();
    end
    pkt = '0;
    wait_beats(9, 40);
    chk("t3_count", mon_data.size(), 9);
    for (int k = 0; k < 9; k++) begin
      if (k < mon_data.size()) begin
        chk($sformatf("t3_grant%0d", k), mon_gid[k], t3_g[k]);
        chk($sformatf("t3_data%0d", k), mon_data[k], t3_d[k]);
        chk($sformatf("t3_last%0d", k), mon_last[k], t3_d[k] != 64'hA0 && t3_d[k] != 64'hA1);
      end
    end

    // overflow with stalled sink
    do_reset();
    tready = 1'b0;
    mon_clear();
    for (int i = 0; i < 18; i++) begin
      pkt[0] = mk(64'h100 + 64'(i), 1'b1);
      step();
    end
    pkt = '0;
    @(negedge clk);
    chk("t4_full", full, 2'b01);
    chk("t4_ovf", ovf, 2'b01);
    chk("t4_stall_tvalid", tvalid, 1);
    chk("t4_stall_data", tdata, 64'h100);
    repeat (3) step();
    @(negedge clk);
    chk("t4_hold_data", tdata, 64'h100);
    step();
    tready = 1'b1;
    wait_beats(17, 40);
    repeat (5) step();
    chk("t4_count", mon_data.size(), 17);
    for (int k = 0; k < 17; k++)
      if (k < mon_data.size()) chk($sformatf("t4_data%0d", k), mon_data[k], 64'h100 + 64'(k));
    @(negedge clk);
    chk("t4_full_clr", full, 0);
    chk("t4_ovf_sticky", ovf, 2'b01);

    // asynchronous reset mid-packet
    step();
    tready = 1'b0;
    mon_clear();
    for (int i = 0; i < 5; i++) begin
      pkt[0] = mk(64'h200 + 64'(i), 1'b0);
      step();
    end
    pkt = '0;
    @(negedge clk);
    chk("t5_pre_tvalid", tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tvalid", tvalid, 0);
    chk("t5_rst_tdata", tdata, 0);
    chk("t5_rst_grant", gid, 0);
    chk("t5_rst_ovf", ovf, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tready = 1'b1;
    repeat (10) step();
    chk("t5_no_stale", mon_data.size(), 0);
    pkt[1] = mk(64'h3C, 1'b1);
    step();
    pkt = '0;
    wait_beats(1, 10);
    chk("t5_new_count", mon_data.size(), 1);
    if (mon_data.size() >= 1) begin
      chk("t5_new_data", mon_data[0], 64'h3C);
      chk("t5_new_grant", mon_gid[0], 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
